store_merge_unit: RTL and testbench
===================================

# store_merge_unit

Sequenced store path that sits directly upstream of memory, opposite the load-size unit that zero-extends byte/halfword reads out of the memory data register. Word stores write the register operand straight through. Byte and halfword stores perform a read-modify-write: read the addressed word, replace its low 8 or 16 bits with the operand, and write the merged word back. This keeps the memory image consistent with the load side, which always takes sub-word data from the low bits. The control FSM drives it with a start/done handshake.

## Interface
- MEM_LATENCY, default 1: cycles from read address presentation to valid mem_data_in; legal range 1..15.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request strobe, sampled only in IDLE.
- store_size_control  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- address  in  32  target address, captured on accept.
- b_data  in  32  store operand, captured on accept.
- mem_data_in  in  32  memory read data.
- mem_addr  out  32  registered address to memory.
- mem_wr  out  1  write enable, high for exactly one cycle per request.
- mem_data_out  out  32  registered write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: wait for start.
  - READ: hold the read address for MEM_LATENCY cycles.
  - WRITE: write the merged or pass-through word.
  - DONE: signal completion.
- IDLE with start=1:
  - Capture address into mem_addr, b_data into the operand register, and store_size_control into the size register.
  - Size 10 or 11: go to WRITE, loading mem_data_out = b_data.
  - Size 00 or 01: go to READ and load the latency counter with MEM_LATENCY-1.
- READ:
  - mem_wr=0 and mem_addr is stable.
  - The counter decrements each cycle.
  - At the edge ending the cycle where the counter is 0:
    - mem_data_out = {mem_data_in[31:8], op[7:0]} for a byte.
    - mem_data_out = {mem_data_in[31:16], op[15:0]} for a halfword.
  - Then go to WRITE.
- WRITE: mem_wr=1 for this cycle only; next state is DONE.
- DONE: done=1 for this cycle only; next state is IDLE.
- start outside IDLE is ignored. It is not queued, and the captured inputs are not disturbed.
- Address bits are not interpreted and no lane shifting is done. The merge always targets the low bits, matching the load-size zero-extension.
- All merge operands are 32 bits. No arithmetic beyond the 4-bit latency counter.

## Timing
- Reset (asynchronous, on reset low):
  - State IDLE; mem_addr, mem_data_out and the counter are 0.
  - mem_wr, busy and done are 0.
  - All of these hold until the first rising edge after reset is released.
- Reset mid-operation aborts immediately. mem_wr drops asynchronously, no write completes, and no done pulse is produced.
- Outputs are decoded from the registered state, so there are no combinational paths from inputs.
- Word store with start high in cycle 0:
  - Cycle 1: WRITE, mem_wr=1.
  - Cycle 2: DONE, done=1.
  - Cycle 3: IDLE, and a new start is accepted there.
- Sub-word store with start high in cycle 0:
  - Cycles 1..MEM_LATENCY: READ.
  - Cycle MEM_LATENCY+1: WRITE.
  - Cycle MEM_LATENCY+2: DONE.
- mem_data_in is sampled only at the final READ edge and ignored at all other times.
- mem_addr and mem_data_out hold their last values after DONE until the next accept.
- Back-to-back requests: the minimum spacing between accepted starts is 3 cycles for word stores and MEM_LATENCY+3 for sub-word stores.

## Test plan
- Reset then idle: hold reset low mid-cycle -> all outputs 0 immediately. Release reset with start=0 -> outputs stay 0 and busy=0.
- Word store, MEM_LATENCY=1:
  - Stimulus: start, size 10, address 0x40, b_data 0xDEADBEEF.
  - Required: mem_wr=1 in cycle 1 with mem_addr 0x40 and mem_data_out 0xDEADBEEF; done=1 in cycle 2; no read cycle.
- Byte store, MEM_LATENCY=3:
  - Stimulus: size 00, b_data 0x123456AB, memory returns 0xCAFEF00D in the final READ cycle.
  - Required: mem_wr=1 in cycle 4 with data 0xCAFEF0AB; done=1 in cycle 5.
- Halfword store, MEM_LATENCY=1:
  - Stimulus: b_data 0x0000BEEF, memory 0x11223344.
  - Required: write data 0x1122BEEF in cycle 2.
  - Also: change mem_data_in during WRITE and confirm the written data is unaffected.
- Start while busy:
  - Stimulus: pulse start with different inputs during READ and DONE.
  - Required: ignored; exactly one mem_wr for the original request.
  - Also: size 11 behaves identically to 10.
- Reset mid-READ, then recovery:
  - Assert reset mid-READ -> mem_wr never rises, done never pulses.
  - After release, a new word store completes normally in 3 cycles.

Source files
------------

// File: rtl/store_merge_unit.sv
// Store path to memory: word stores pass straight through, byte/halfword stores
// read the addressed word and merge the operand into its low bits before writing back.
module store_merge_unit #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_size_control,
  input  logic [31:0] address,
  input  logic [31:0] b_data,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_data_out,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LatLoad = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  // Only the low halfword of the operand ever reaches memory via the merge path.
  logic [15:0] op_q, op_d;
  logic        half_q, half_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    half_d  = half_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d = address;
          op_d   = b_data[15:0];
          half_d = store_size_control[0];
          if (store_size_control[1]) begin
            wdata_d = b_data;
            state_d = StWrite;
          end else begin
            cnt_d   = LatLoad;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (cnt_q == 4'd0) begin
          wdata_d = half_q ? {mem_data_in[31:16], op_q}
                           : {mem_data_in[31:8], op_q[7:0]};
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      half_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode registered state only; no input-to-output paths.
  always_comb begin
    mem_addr     = addr_q;
    mem_data_out = wdata_q;
    mem_wr       = (state_q == StWrite);
    done         = (state_q == StDone);
    busy         = (state_q != StIdle);
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: two instances (MEM_LATENCY 1 and 3); a scoreboard
// monitor checks every memory write against queued expectations.
module tb_store_merge_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        start_s   [2];
  logic [1:0]  size_s    [2];
  logic [31:0] addr_s    [2];
  logic [31:0] bdata_s   [2];
  logic [31:0] mem_in_s  [2];
  logic [31:0] mem_addr_w[2];
  logic [31:0] mem_do_w  [2];
  logic        mem_wr_w  [2];
  logic        busy_w    [2];
  logic        done_w    [2];

  wr_t exp_q0[$];
  wr_t exp_q1[$];
  int  checks   = 0;
  int  failures = 0;

  store_merge_unit #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .start(start_s[0]), .store_size_control(size_s[0]),
    .address(addr_s[0]), .b_data(bdata_s[0]), .mem_data_in(mem_in_s[0]),
    .mem_addr(mem_addr_w[0]), .mem_wr(mem_wr_w[0]), .mem_data_out(mem_do_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  store_merge_unit #(.MEM_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .start(start_s[1]), .store_size_control(size_s[1]),
    .address(addr_s[1]), .b_data(bdata_s[1]), .mem_data_in(mem_in_s[1]),
    .mem_addr(mem_addr_w[1]), .mem_wr(mem_wr_w[1]), .mem_data_out(mem_do_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic mon_check(input int i);
    wr_t e;
    bit  got;
    got = 1'b0;
    e   = '0;
    if (i == 0 && exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      got = 1'b1;
    end else if (i == 1 && exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL unexpected_write dut%0d: got addr %h data %h expected no write",
               i, mem_addr_w[i], mem_do_w[i]);
    end else begin
      chk($sformatf("wr_addr dut%0d", i), mem_addr_w[i], e.addr);
      chk($sformatf("wr_data dut%0d", i), mem_do_w[i], e.data);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mem_wr_w[0] === 1'b1) mon_check(0);
    if (mem_wr_w[1] === 1'b1) mon_check(1);
  end

  // Called at a falling edge (cycle 0); returns at the falling edge of the idle
  // cycle that follows DONE, where a new start may be issued immediately.
  task automatic do_store(input int idx, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] bdata, input logic [31:0] memval,
                          input logic [31:0] expdata, input bit poke);
    int lat;
    int wcyc;
    wr_t e;
    lat  = (idx == 0) ? 1 : 3;
    wcyc = size[1] ? 1 : lat + 1;
    e.addr = addr;
    e.data = expdata;
    if (idx == 0) exp_q0.push_back(e);
    else          exp_q1.push_back(e);
    start_s[idx]  = 1'b1;
    size_s[idx]   = size;
    addr_s[idx]   = addr;
    bdata_s[idx]  = bdata;
    mem_in_s[idx] = 32'hA5A5_A5A5;
    for (int c = 1; c <= wcyc + 2; c++) begin
      @(posedge clk);
      #1;
      if (poke && (c == 1 || c == wcyc + 1)) begin
        start_s[idx] = 1'b1;
        size_s[idx]  = 2'b10;
        addr_s[idx]  = 32'hFFFF_0000;
        bdata_s[idx] = 32'h7777_7777;
      end else begin
        start_s[idx] = 1'b0;
      end
      // Memory data is valid only in the final READ cycle; garbage elsewhere.
      mem_in_s[idx] = (!size[1] && c == lat) ? memval : 32'h5A5A_5A5A ^ c;
      @(negedge clk);
      chk($sformatf("mem_wr dut%0d c%0d", idx, c), {31'b0, mem_wr_w[idx]},
          {31'b0, c == wcyc});
      chk($sformatf("done dut%0d c%0d", idx, c), {31'b0, done_w[idx]},
          {31'b0, c == wcyc + 1});
      chk($sformatf("busy dut%0d c%0d", idx, c), {31'b0, busy_w[idx]},
          {31'b0, c <= wcyc + 1});
      if (c <= wcyc) chk($sformatf("addr_held dut%0d c%0d", idx, c), mem_addr_w[idx], addr);
    end
    start_s[idx] = 1'b0;
    chk($sformatf("data_held dut%0d", idx), mem_do_w[idx], expdata);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_s[i]  = 1'b0;
      size_s[i]   = 2'b00;
      addr_s[i]   = '0;
      bdata_s[i]  = '0;
      mem_in_s[i] = '0;
    end
    reset = 1'b0;
    #3;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_addr dut%0d", i), mem_addr_w[i], 32'h0);
      chk($sformatf("rst_data dut%0d", i), mem_do_w[i], 32'h0);
      chk($sformatf("rst_ctl dut%0d", i), {29'b0, mem_wr_w[i], busy_w[i], done_w[i]}, 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("idle_ctl dut%0d", i), {29'b0, mem_wr_w[i], busy_w[i], done_w[i]}, 32'h0);
      chk($sformatf("idle_addr dut%0d", i), mem_addr_w[i], 32'h0);
    end

    // Latency 1 instance: word, halfword, size 11, byte, back-to-back.
    do_store(0, 2'b10, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0);
    do_store(0, 2'b01, 32'h0000_0080, 32'h0000_BEEF, 32'h1122_3344, 32'h1122_BEEF, 1'b0);
    do_store(0, 2'b11, 32'h0000_0044, 32'h0123_4567, 32'h0, 32'h0123_4567, 1'b0);
    do_store(0, 2'b00, 32'h0000_0048, 32'hFFFF_FF5A, 32'h0000_0000, 32'h0000_005A, 1'b0);

    // Latency 3 instance: byte, halfword with ignored starts, word with ignored starts.
    do_store(1, 2'b00, 32'h0000_0100, 32'h1234_56AB, 32'hCAFE_F00D, 32'hCAFE_F0AB, 1'b0);
    do_store(1, 2'b01, 32'h0000_0200, 32'hA1B2_C3D4, 32'h5566_7788, 32'h5566_C3D4, 1'b1);
    do_store(1, 2'b10, 32'h0000_0204, 32'h8765_4321, 32'h0, 32'h8765_4321, 1'b1);

    // Abort a sub-word store mid-READ; no write or done may follow.
    start_s[1] = 1'b1;
    size_s[1]  = 2'b00;
    addr_s[1]  = 32'h0000_0300;
    bdata_s[1] = 32'h0000_00EE;
    @(posedge clk);
    #1 start_s[1] = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_ctl", {29'b0, mem_wr_w[1], busy_w[1], done_w[1]}, 32'h0);
    chk("abort_addr", mem_addr_w[1], 32'h0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_quiet", {30'b0, mem_wr_w[1], done_w[1]}, 32'h0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("abort_idle", {31'b0, busy_w[1]}, 32'h0);
    do_store(1, 2'b10, 32'h0000_0300, 32'h0BAD_F00D, 32'h0, 32'h0BAD_F00D, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty dut0", exp_q0.size(), 32'd0);
    chk("sb_empty dut1", exp_q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
